apb_ram_slave: RTL

APB_RAM_SLAVE -- requirements
Module: apb_ram_slave

---
 rtl/apb_ram_pkg.sv | 13 +
 rtl/apb_ram_bank.sv | 36 +++
 rtl/apb_ram_slave.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/apb_ram_pkg.sv
// Shared types and limits for the APB RAM slave.
package apb_ram_pkg;

  localparam int unsigned WAIT_STATES_MAX = 15;
  localparam int unsigned WAIT_CNT_W      = $clog2(WAIT_STATES_MAX + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/apb_ram_bank.sv
// DEPTH x DWIDTH single-port RAM: byte-strobed synchronous write, synchronous read.
// The read register returns zero whenever no read is requested.
module apb_ram_bank #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned SWIDTH = DWIDTH / 8,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RAW    = 10
) (
  input  logic              i_ck,
  input  logic              i_rst_n,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [RAW-1:0]    addr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic [SWIDTH-1:0] strb,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [DEPTH];

  // Storage is intentionally never reset.
  always_ff @(posedge i_ck) begin
    if (wr_en) begin
      for (int i = 0; i < int'(SWIDTH); i++) begin
        if (strb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_ck) begin
    if (!i_rst_n)   rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
    else            rdata <= '0;
  end

endmodule

// File: rtl/apb_ram_slave.sv
// APB slave backed by a word RAM, with configurable wait states.
// Define APB_RAM_PROT_EN to reject non-secure (prot[1]=1) transfers.
module apb_ram_slave
  import apb_ram_pkg::*;
#(
  parameter int unsigned AWIDTH      = 12,
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned SWIDTH      = DWIDTH / 8,
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              i_ck,
  input  logic              i_rst_n,
  input  logic              i_sel,
  input  logic              i_enable,
  input  logic [AWIDTH-1:0] i_addr,
  input  logic              i_write,
  input  logic [DWIDTH-1:0] i_wdata,
  input  logic [SWIDTH-1:0] i_strb,
  input  logic [2:0]        i_prot,
  output logic [DWIDTH-1:0] o_rdata,
  output logic              o_ready,
  output logic              o_slverr
);

  localparam int unsigned LSB = $clog2(SWIDTH);
  localparam int unsigned RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    WAIT_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e                state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [AWIDTH-1:0]     addr_q;
  logic                  write_q;
  logic [DWIDTH-1:0]     wdata_q;
  logic [SWIDTH-1:0]     strb_q;
  logic [2:0]            prot_q;
  logic                  load_c, wr_en_c, rd_en_c;

  // In IDLE the live bus is decoded so the RAM read can launch on the setup edge.
  logic [AWIDTH-1:0] cur_addr;
  logic              cur_write;
  logic [AWIDTH-1:0] cur_idx;
  logic              misalign_c, range_err_c, prot_err_c, err_c;

  assign cur_addr    = (state_q == IDLE) ? i_addr  : addr_q;
  assign cur_write   = (state_q == IDLE) ? i_write : write_q;
  assign cur_idx     = cur_addr >> LSB;
  assign misalign_c  = |(cur_addr & AWIDTH'(SWIDTH - 1));
  assign range_err_c = 32'(cur_idx) >= DEPTH;

`ifdef APB_RAM_PROT_EN
  logic [2:0] cur_prot;
  assign cur_prot   = (state_q == IDLE) ? i_prot : prot_q;
  assign prot_err_c = cur_prot[1];
`else
  logic unused_prot;
  assign unused_prot = ^prot_q;
  assign prot_err_c  = 1'b0;
`endif

  assign err_c = misalign_c | range_err_c | prot_err_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    wr_en_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_sel && !i_enable) begin
          load_c = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!i_sel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        wr_en_c = i_rst_n && i_sel && i_enable && write_q && !err_c;
      end
      default: state_d = IDLE;
    endcase
    rd_en_c = i_rst_n && (state_d == DONE) && !cur_write && !err_c;
  end

  always_ff @(posedge i_ck) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      o_ready  <= 1'b0;
      o_slverr <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      o_ready  <= (state_d == DONE);
      o_slverr <= (state_d == DONE) && err_c;
    end
  end

  // Transfer attributes captured at the setup edge.
  always_ff @(posedge i_ck) begin
    if (load_c) begin
      addr_q  <= i_addr;
      write_q <= i_write;
      wdata_q <= i_wdata;
      strb_q  <= i_strb;
      prot_q  <= i_prot;
    end
  end

  apb_ram_bank #(
    .DWIDTH (DWIDTH),
    .SWIDTH (SWIDTH),
    .DEPTH  (DEPTH),
    .RAW    (RAW)
  ) u_bank (
    .i_ck    (i_ck),
    .i_rst_n (i_rst_n),
    .rd_en   (rd_en_c),
    .wr_en   (wr_en_c),
    .addr    (RAW'(cur_idx)),
    .wdata   (wdata_q),
    .strb    (strb_q),
    .rdata   (o_rdata)
  );

endmodule
